// File: rtl/inst_test_checker.sv
// inst_test_checker
//   Hardware scoreboard for the cache-lab CPU bench. Holds a loadable table
//   of (instruction count, expected output) pairs, compares the CPU debug
//   outputs against it every cycle of a run, ends the run on halt, timeout
//   or (optionally) the first mismatch, then tallies per-entry results.
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   start                   one-cycle pulse that begins a run (LOAD/DONE)
//   tbl_we/addr/num_inst/ans  table write port, honoured only in LOAD
//   num_inst, output_port   CPU retired-instruction count and WWD output
//   is_halted               CPU halted
//   busy, done, all_pass    status flags
//   finish_cause            00 none, 01 halt, 10 timeout, 11 fail
//   num_clock               cycles in current/last run
//   pass/fail/noresult_count  summary tallies
//   first_fail_*            capture of the first failing comparison
module inst_test_checker #(
  parameter int WORD_SIZE    = 16,
  parameter int NUM_TEST     = 56,
  parameter int IDX_W        = 6,
  parameter int CYC_W        = 16,
  parameter int MAX_CYCLES   = 10000,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 tbl_we,
  input  logic [IDX_W-1:0]     tbl_addr,
  input  logic [WORD_SIZE-1:0] tbl_num_inst,
  input  logic [WORD_SIZE-1:0] tbl_ans,
  input  logic [WORD_SIZE-1:0] num_inst,
  input  logic [WORD_SIZE-1:0] output_port,
  input  logic                 is_halted,
  output logic                 busy,
  output logic                 done,
  output logic                 all_pass,
  output logic [1:0]           finish_cause,
  output logic [CYC_W-1:0]     num_clock,
  output logic [IDX_W:0]       pass_count,
  output logic [IDX_W:0]       fail_count,
  output logic [IDX_W:0]       noresult_count,
  output logic                 first_fail_valid,
  output logic [IDX_W-1:0]     first_fail_idx,
  output logic [WORD_SIZE-1:0] first_fail_value
);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_SUMM, S_DONE} state_t;
  typedef enum logic [1:0] {R_UNSEEN, R_PASS, R_FAIL} res_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TEST - 1);

  state_t               state, state_n;
  res_t                 res [NUM_TEST];
  logic [WORD_SIZE-1:0] key_mem [NUM_TEST];
  logic [WORD_SIZE-1:0] ans_mem [NUM_TEST];
  logic [IDX_W-1:0]     scan;

  logic [NUM_TEST-1:0]  cmp_pass, cmp_fail;
  logic                 any_fail, found;
  logic [IDX_W-1:0]     fail_idx;
  res_t                 cur_res;
  logic                 run_entry, finish, timeout;
  logic [1:0]           cause_n;

  // Table storage is deliberately not reset so a run can be repeated after reset.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && tbl_we) begin
      for (int unsigned i = 0; i < NUM_TEST; i++) begin
        if (tbl_addr == IDX_W'(i)) begin
          key_mem[i] <= tbl_num_inst;
          ans_mem[i] <= tbl_ans;
        end
      end
    end
  end

  // Parallel compare of every entry; lowest failing index found by first hit.
  always_comb begin
    cmp_pass = '0;
    cmp_fail = '0;
    fail_idx = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_TEST; i++) begin
      if (key_mem[i] == num_inst) begin
        cmp_pass[i] = (output_port == ans_mem[i]);
        cmp_fail[i] = (output_port != ans_mem[i]);
      end
    end
    any_fail = |cmp_fail;
    for (int unsigned i = 0; i < NUM_TEST; i++) begin
      if (cmp_fail[i] && !found) begin
        fail_idx = IDX_W'(i);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    cur_res = R_UNSEEN;
    for (int unsigned i = 0; i < NUM_TEST; i++) begin
      if (scan == IDX_W'(i)) cur_res = res[i];
    end
  end

  assign timeout = (num_clock == CYC_W'(MAX_CYCLES - 1));

  always_comb begin
    state_n   = state;
    run_entry = 1'b0;
    finish    = 1'b0;
    cause_n   = 2'b00;
    case (state)
      S_LOAD: if (start) begin
        state_n   = S_RUN;
        run_entry = 1'b1;
      end
      S_RUN: begin
        if (any_fail && STOP_ON_FAIL != 0) begin
          finish  = 1'b1;
          cause_n = 2'b11;
        end else if (is_halted) begin
          finish  = 1'b1;
          cause_n = 2'b01;
        end else if (timeout) begin
          finish  = 1'b1;
          cause_n = 2'b10;
        end
        if (finish) state_n = S_SUMM;
      end
      S_SUMM: if (scan == LAST_IDX) state_n = S_DONE;
      S_DONE: if (start) begin
        state_n   = S_RUN;
        run_entry = 1'b1;
      end
      default: state_n = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_LOAD;
      busy             <= 1'b0;
      done             <= 1'b0;
      all_pass         <= 1'b0;
      finish_cause     <= 2'b00;
      num_clock        <= '0;
      pass_count       <= '0;
      fail_count       <= '0;
      noresult_count   <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_value <= '0;
      scan             <= '0;
      for (int unsigned i = 0; i < NUM_TEST; i++) res[i] <= R_UNSEEN;
    end else begin
      state <= state_n;
      busy  <= (state_n == S_RUN) || (state_n == S_SUMM);
      done  <= (state_n == S_DONE);
      if (run_entry) begin
        all_pass         <= 1'b0;
        finish_cause     <= 2'b00;
        num_clock        <= '0;
        pass_count       <= '0;
        fail_count       <= '0;
        noresult_count   <= '0;
        first_fail_valid <= 1'b0;
        first_fail_idx   <= '0;
        first_fail_value <= '0;
        for (int unsigned i = 0; i < NUM_TEST; i++) res[i] <= R_UNSEEN;
      end else if (state == S_RUN) begin
        num_clock <= num_clock + 1'b1;
        for (int unsigned i = 0; i < NUM_TEST; i++) begin
          if (cmp_pass[i])      res[i] <= R_PASS;
          else if (cmp_fail[i]) res[i] <= R_FAIL;
        end
        if (any_fail && !first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_idx   <= fail_idx;
          first_fail_value <= output_port;
        end
        if (finish) begin
          finish_cause <= cause_n;
          scan         <= '0;
        end
      end else if (state == S_SUMM) begin
        case (cur_res)
          R_PASS:  pass_count     <= pass_count + 1'b1;
          R_FAIL:  fail_count     <= fail_count + 1'b1;
          default: noresult_count <= noresult_count + 1'b1;
        endcase
        scan <= scan + 1'b1;
        // Fold in the final entry's contribution since pass_count lags by one.
        if (scan == LAST_IDX)
          all_pass <= ((pass_count + (IDX_W+1)'(cur_res == R_PASS)) == (IDX_W+1)'(NUM_TEST));
      end
    end
  end

endmodule

// File: tb/tb_inst_test_checker.sv
module tb_inst_test_checker;

  localparam int WS = 16;
  localparam int NT = 3;
  localparam int IW = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset, start, tbl_we, is_halted;
  logic [IW-1:0] tbl_addr;
  logic [WS-1:0] tbl_num_inst, tbl_ans, num_inst, output_port;

  logic a_busy, a_done, a_all_pass, a_ffv;
  logic [1:0] a_cause;
  logic [CW-1:0] a_nclk;
  logic [IW:0] a_pass, a_fail, a_nores;
  logic [IW-1:0] a_ffi;
  logic [WS-1:0] a_ffval;

  logic b_busy, b_done, b_all_pass, b_ffv;
  logic [1:0] b_cause;
  logic [CW-1:0] b_nclk;
  logic [IW:0] b_pass, b_fail, b_nores;
  logic [IW-1:0] b_ffi;
  logic [WS-1:0] b_ffval;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  inst_test_checker #(.WORD_SIZE(WS), .NUM_TEST(NT), .IDX_W(IW), .CYC_W(CW),
                      .MAX_CYCLES(20), .STOP_ON_FAIL(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_num_inst(tbl_num_inst), .tbl_ans(tbl_ans), .num_inst(num_inst),
    .output_port(output_port), .is_halted(is_halted), .busy(a_busy), .done(a_done),
    .all_pass(a_all_pass), .finish_cause(a_cause), .num_clock(a_nclk),
    .pass_count(a_pass), .fail_count(a_fail), .noresult_count(a_nores),
    .first_fail_valid(a_ffv), .first_fail_idx(a_ffi), .first_fail_value(a_ffval));

  inst_test_checker #(.WORD_SIZE(WS), .NUM_TEST(NT), .IDX_W(IW), .CYC_W(CW),
                      .MAX_CYCLES(20), .STOP_ON_FAIL(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_num_inst(tbl_num_inst), .tbl_ans(tbl_ans), .num_inst(num_inst),
    .output_port(output_port), .is_halted(is_halted), .busy(b_busy), .done(b_done),
    .all_pass(b_all_pass), .finish_cause(b_cause), .num_clock(b_nclk),
    .pass_count(b_pass), .fail_count(b_fail), .noresult_count(b_nores),
    .first_fail_valid(b_ffv), .first_fail_idx(b_ffi), .first_fail_value(b_ffval));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // num_inst 0..7 (entry answers 0,0,2 at keys 3,5,7), then a one-cycle halt.
  task automatic drive_seq(input bit bad5);
    for (int n = 0; n < 8; n++) begin
      num_inst    = WS'(n);
      output_port = (n == 7) ? 16'd2 : ((n == 5 && bad5) ? 16'd1 : 16'd0);
      step();
    end
    is_halted = 1'b1;
    step();
    is_halted   = 1'b0;
    num_inst    = '0;
    output_port = '0;
  endtask

  task automatic test_reset;
    vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0d expected 0", a_busy); end
    vectors++; if (a_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0d expected 0", a_done); end
    vectors++; if (a_cause !== 2'd0) begin miscompares++; $display("FAIL reset_cause got %0d expected 0", a_cause); end
    vectors++; if (a_nclk !== 16'd0) begin miscompares++; $display("FAIL reset_num_clock got %0d expected 0", a_nclk); end
    vectors++; if (a_pass !== 3'd0 || a_fail !== 3'd0 || a_nores !== 3'd0) begin miscompares++; $display("FAIL reset_counts got %0d/%0d/%0d expected 0/0/0", a_pass, a_fail, a_nores); end
    vectors++; if (a_ffv !== 1'b0) begin miscompares++; $display("FAIL reset_ff_valid got %0d expected 0", a_ffv); end
    vectors++; if (a_all_pass !== 1'b0) begin miscompares++; $display("FAIL reset_all_pass got %0d expected 0", a_all_pass); end
  endtask

  task automatic load_table;
    logic [WS-1:0] keys [4] = '{16'd3, 16'd5, 16'd7, 16'd7};
    logic [WS-1:0] anss [4] = '{16'd0, 16'd0, 16'd2, 16'd5};
    // Address 3 is beyond NUM_TEST and must be dropped.
    for (int i = 0; i < 4; i++) begin
      tbl_we = 1'b1; tbl_addr = IW'(i); tbl_num_inst = keys[i]; tbl_ans = anss[i];
      step();
    end
    tbl_we = 1'b0;
  endtask

  task automatic test_halt_pass;
    pulse_start();
    vectors++; if (a_busy !== 1'b1) begin miscompares++; $display("FAIL start_busy got %0d expected 1", a_busy); end
    vectors++; if (a_nclk !== 16'd0) begin miscompares++; $display("FAIL start_num_clock got %0d expected 0", a_nclk); end
    drive_seq(1'b0);
    vectors++; if (a_cause !== 2'd1) begin miscompares++; $display("FAIL halt_cause got %0d expected 1", a_cause); end
    // start during SUMM must be ignored
    start = 1'b1; step(); start = 1'b0;
    step();
    vectors++; if (a_done !== 1'b0) begin miscompares++; $display("FAIL halt_done_early got %0d expected 0", a_done); end
    step();
    vectors++; if (a_done !== 1'b1) begin miscompares++; $display("FAIL halt_done got %0d expected 1", a_done); end
    vectors++; if (a_pass !== 3'd3 || a_fail !== 3'd0 || a_nores !== 3'd0) begin miscompares++; $display("FAIL halt_counts got %0d/%0d/%0d expected 3/0/0", a_pass, a_fail, a_nores); end
    vectors++; if (a_all_pass !== 1'b1) begin miscompares++; $display("FAIL halt_all_pass got %0d expected 1", a_all_pass); end
    vectors++; if (a_nclk !== 16'd9) begin miscompares++; $display("FAIL halt_num_clock got %0d expected 9", a_nclk); end
    vectors++; if (a_ffv !== 1'b0) begin miscompares++; $display("FAIL halt_ff_valid got %0d expected 0", a_ffv); end
    vectors++; if (b_pass !== 3'd3 || b_done !== 1'b1) begin miscompares++; $display("FAIL halt_b got pass %0d done %0d expected 3 1", b_pass, b_done); end
  endtask

  task automatic test_stop_on_fail;
    pulse_start();
    drive_seq(1'b1);
    repeat (3) step();
    vectors++; if (a_done !== 1'b1) begin miscompares++; $display("FAIL sof_done got %0d expected 1", a_done); end
    vectors++; if (a_cause !== 2'd3) begin miscompares++; $display("FAIL sof_cause got %0d expected 3", a_cause); end
    vectors++; if (a_ffv !== 1'b1 || a_ffi !== 2'd1 || a_ffval !== 16'd1) begin miscompares++; $display("FAIL sof_first_fail got %0d/%0d/%0d expected 1/1/1", a_ffv, a_ffi, a_ffval); end
    vectors++; if (a_pass !== 3'd1 || a_fail !== 3'd1 || a_nores !== 3'd1) begin miscompares++; $display("FAIL sof_counts got %0d/%0d/%0d expected 1/1/1", a_pass, a_fail, a_nores); end
    vectors++; if (a_nclk !== 16'd6) begin miscompares++; $display("FAIL sof_num_clock got %0d expected 6", a_nclk); end
    vectors++; if (a_all_pass !== 1'b0) begin miscompares++; $display("FAIL sof_all_pass got %0d expected 0", a_all_pass); end
    vectors++; if (b_done !== 1'b1 || b_cause !== 2'd1) begin miscompares++; $display("FAIL nostop_cause got done %0d cause %0d expected 1 1", b_done, b_cause); end
    vectors++; if (b_pass !== 3'd2 || b_fail !== 3'd1 || b_nores !== 3'd0) begin miscompares++; $display("FAIL nostop_counts got %0d/%0d/%0d expected 2/1/0", b_pass, b_fail, b_nores); end
    vectors++; if (b_ffi !== 2'd1 || b_ffval !== 16'd1) begin miscompares++; $display("FAIL nostop_first_fail got %0d/%0d expected 1/1", b_ffi, b_ffval); end
  endtask

  task automatic test_timeout;
    pulse_start();
    num_inst = '0; output_port = '0;
    step();
    vectors++; if (a_nclk !== 16'd1) begin miscompares++; $display("FAIL to_num_clock1 got %0d expected 1", a_nclk); end
    repeat (18) step();
    vectors++; if (a_nclk !== 16'd19 || a_cause !== 2'd0 || a_busy !== 1'b1) begin miscompares++; $display("FAIL to_before got clk %0d cause %0d busy %0d expected 19 0 1", a_nclk, a_cause, a_busy); end
    step();
    vectors++; if (a_nclk !== 16'd20 || a_cause !== 2'd2) begin miscompares++; $display("FAIL to_fire got clk %0d cause %0d expected 20 2", a_nclk, a_cause); end
    repeat (3) step();
    vectors++; if (a_done !== 1'b1 || a_nores !== 3'd3 || a_nclk !== 16'd20) begin miscompares++; $display("FAIL to_summary got done %0d nores %0d clk %0d expected 1 3 20", a_done, a_nores, a_nclk); end
    vectors++; if (b_cause !== 2'd2) begin miscompares++; $display("FAIL to_b_cause got %0d expected 2", b_cause); end
  endtask

  task automatic test_priority;
    pulse_start();
    num_inst = 16'd5; output_port = 16'd1; is_halted = 1'b1;
    step();
    is_halted = 1'b0; num_inst = '0; output_port = '0;
    repeat (3) step();
    vectors++; if (a_cause !== 2'd3 || a_fail !== 3'd1 || a_nores !== 3'd2) begin miscompares++; $display("FAIL prio_fail_halt got cause %0d fail %0d nores %0d expected 3 1 2", a_cause, a_fail, a_nores); end
    vectors++; if (b_cause !== 2'd1 || b_fail !== 3'd1 || b_ffv !== 1'b1) begin miscompares++; $display("FAIL prio_b got cause %0d fail %0d ffv %0d expected 1 1 1", b_cause, b_fail, b_ffv); end
    vectors++; if (a_nclk !== 16'd1) begin miscompares++; $display("FAIL prio_num_clock got %0d expected 1", a_nclk); end
    pulse_start();
    num_inst = 16'd7; output_port = 16'd2; is_halted = 1'b1;
    step();
    is_halted = 1'b0; num_inst = '0; output_port = '0;
    repeat (3) step();
    vectors++; if (a_cause !== 2'd1 || a_pass !== 3'd1 || a_nores !== 3'd2 || a_fail !== 3'd0) begin miscompares++; $display("FAIL prio_pass_halt got cause %0d pass %0d nores %0d fail %0d expected 1 1 2 0", a_cause, a_pass, a_nores, a_fail); end
  endtask

  task automatic test_done_write;
    tbl_we = 1'b1; tbl_addr = 2'd2; tbl_num_inst = 16'd0; tbl_ans = 16'd9;
    step();
    tbl_we = 1'b0;
    pulse_start();
    drive_seq(1'b0);
    repeat (3) step();
    vectors++; if (a_pass !== 3'd3 || a_all_pass !== 1'b1 || a_cause !== 2'd1) begin miscompares++; $display("FAIL done_write got pass %0d all %0d cause %0d expected 3 1 1", a_pass, a_all_pass, a_cause); end
  endtask

  task automatic test_reset_summ;
    pulse_start();
    drive_seq(1'b0);
    step();
    reset = 1'b1;
    #1;
    vectors++; if (a_busy !== 1'b0 || a_done !== 1'b0 || b_busy !== 1'b0) begin miscompares++; $display("FAIL rst_summ_flags got %0d/%0d/%0d expected 0/0/0", a_busy, a_done, b_busy); end
    vectors++; if (a_pass !== 3'd0 || a_cause !== 2'd0 || a_nclk !== 16'd0) begin miscompares++; $display("FAIL rst_summ_state got pass %0d cause %0d clk %0d expected 0 0 0", a_pass, a_cause, a_nclk); end
    step();
    reset = 1'b0;
    step();
    pulse_start();
    drive_seq(1'b0);
    repeat (3) step();
    vectors++; if (a_done !== 1'b1 || a_pass !== 3'd3 || a_all_pass !== 1'b1 || a_cause !== 2'd1) begin miscompares++; $display("FAIL rst_rerun got done %0d pass %0d all %0d cause %0d expected 1 3 1 1", a_done, a_pass, a_all_pass, a_cause); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tbl_we = 1'b0; tbl_addr = '0;
    tbl_num_inst = '0; tbl_ans = '0; num_inst = '0; output_port = '0; is_halted = 1'b0;
    step(); step();
    test_reset();
    reset = 1'b0;
    step();
    load_table();
    test_halt_pass();
    test_stop_on_fail();
    test_timeout();
    test_priority();
    test_done_write();
    test_reset_summ();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
